// File: rtl/usb_handshake_tx_sched_pkg.sv
// Shared USB transmit definitions: handshake PID codes, scheduler state
// encoding, default packet framing lengths and a small constant helper.
package usb_pkg;

    typedef logic [3:0] pid_t;

    localparam pid_t PID_ACK   = 4'b0010;
    localparam pid_t PID_NAK   = 4'b1010;
    localparam pid_t PID_STALL = 4'b1110;

    localparam int unsigned SYNC_BITS_DEF = 8;
    localparam int unsigned EOP_BITS_DEF  = 2;
    localparam int unsigned GAP_BITS_DEF  = 2;
    localparam int unsigned PID_BITS      = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_PID  = 3'd2,
        ST_EOP  = 3'd3,
        ST_GAP  = 3'd4
    } tx_state_e;

    // Larger of two sizes, used to size the per-state bit counter.
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_handshake_tx_sched_if.sv
// Handshake scheduler bus: bit strobe and request pulses in, NRZ bit stream,
// line control and status out.
//   master : the scheduler (consumes strobe/requests, drives tx/status)
//   slave  : the surrounding endpoint logic / line driver
interface usb_handshake_tx_sched_if;
    import usb_pkg::*;

    logic checkData;
    logic reqAck;
    logic reqNak;
    logic reqStall;
    logic txData;
    logic txOE;
    logic callEop;
    logic busy;
    pid_t grantPid;
    logic done;
    logic dropped;

    modport master (
        input  checkData, reqAck, reqNak, reqStall,
        output txData, txOE, callEop, busy, grantPid, done, dropped
    );

    modport slave (
        output checkData, reqAck, reqNak, reqStall,
        input  txData, txOE, callEop, busy, grantPid, done, dropped
    );
endinterface

// File: rtl/usb_handshake_tx_sched_pid_serializer.sv
// PID serializer: returns bit i_idx (LSB first) of the PID byte {~pid, pid}.
// Ports: i_pid - 4-bit PID, i_idx - bit index 0..7, o_bit_c - raw NRZ bit.
module usb_pid_serializer
    import usb_pkg::*;
(
    input  pid_t       i_pid,
    input  logic [2:0] i_idx,
    output logic       o_bit_c
);
    logic [7:0] w_pid_byte;

    assign w_pid_byte = {~i_pid, i_pid};
    assign o_bit_c    = w_pid_byte[i_idx];
endmodule

// File: rtl/usb_handshake_tx_sched.sv
// Device-side handshake transmit scheduler. Latches ACK/NAK/STALL requests,
// grants one by fixed priority (STALL > NAK > ACK) on a bit strobe while idle,
// then emits SYNC, PID, EOP and an inter-packet gap, one bit per strobe.
// Ports: useClk - clock, rst - synchronous active-high reset,
//        bus    - strobe/request inputs and tx/status outputs (master side).
module usb_handshake_tx_sched
    import usb_pkg::*;
#(
    parameter int unsigned SYNC_BITS = SYNC_BITS_DEF,
    parameter int unsigned EOP_BITS  = EOP_BITS_DEF,
    parameter int unsigned GAP_BITS  = GAP_BITS_DEF
) (
    input  logic                     useClk,
    input  logic                     rst,
    usb_handshake_tx_sched_if.master bus
);
    localparam int unsigned CNT_MAX = max2(max2(SYNC_BITS, PID_BITS), max2(EOP_BITS, GAP_BITS));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    tx_state_e        r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [2:0]       r_pend,      w_pend_nxt;   // {stall, nak, ack}
    logic [2:0]       w_clr;
    logic             r_tx_data,   w_tx_data_nxt;
    logic             r_tx_oe,     w_tx_oe_nxt;
    logic             r_call_eop,  w_call_eop_nxt;
    logic             r_busy,      w_busy_nxt;
    pid_t             r_grant_pid, w_grant_pid_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_dropped,   w_dropped_nxt;
    logic             w_pid_bit;

    usb_pid_serializer u_pid_ser (
        .i_pid   (r_grant_pid),
        .i_idx   (r_cnt[2:0]),
        .o_bit_c (w_pid_bit)
    );

    // State and output registers.
    always_ff @(posedge useClk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pend      <= '0;
            r_tx_data   <= 1'b0;
            r_tx_oe     <= 1'b0;
            r_call_eop  <= 1'b0;
            r_busy      <= 1'b0;
            r_grant_pid <= '0;
            r_done      <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend      <= w_pend_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_oe     <= w_tx_oe_nxt;
            r_call_eop  <= w_call_eop_nxt;
            r_busy      <= w_busy_nxt;
            r_grant_pid <= w_grant_pid_nxt;
            r_done      <= w_done_nxt;
            r_dropped   <= w_dropped_nxt;
        end
    end

    // Arbitration and bit sequencing; r_cnt counts strobes consumed in the
    // current state, so the launch strobe already counts as SYNC bit 0.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_tx_data_nxt   = r_tx_data;
        w_tx_oe_nxt     = r_tx_oe;
        w_call_eop_nxt  = r_call_eop;
        w_busy_nxt      = r_busy;
        w_grant_pid_nxt = r_grant_pid;
        w_done_nxt      = 1'b0;
        w_dropped_nxt   = 1'b0;
        w_clr           = 3'b000;

        if (bus.checkData) begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_pend) begin
                        // Winner and every lower-priority request are cleared.
                        if (r_pend[2]) begin
                            w_grant_pid_nxt = PID_STALL;
                            w_clr           = 3'b111;
                            w_dropped_nxt   = |r_pend[1:0];
                        end else if (r_pend[1]) begin
                            w_grant_pid_nxt = PID_NAK;
                            w_clr           = 3'b011;
                            w_dropped_nxt   = r_pend[0];
                        end else begin
                            w_grant_pid_nxt = PID_ACK;
                            w_clr           = 3'b001;
                        end
                        w_tx_oe_nxt    = 1'b1;
                        w_busy_nxt     = 1'b1;
                        w_call_eop_nxt = 1'b0;
                        w_tx_data_nxt  = (SYNC_BITS == 1);
                        if (SYNC_BITS == 1) begin
                            w_state_nxt = ST_PID;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_SYNC;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                ST_SYNC: begin
                    w_tx_data_nxt = (r_cnt == CNT_W'(SYNC_BITS - 1));
                    if (r_cnt == CNT_W'(SYNC_BITS - 1)) begin
                        w_state_nxt = ST_PID;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
                    end
                end
                ST_PID: begin
                    w_tx_data_nxt = w_pid_bit;
                    if (r_cnt == CNT_W'(PID_BITS - 1)) begin
                        w_state_nxt = ST_EOP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
                    end
                end
                ST_EOP: begin
                    w_tx_data_nxt  = 1'b0;
                    w_call_eop_nxt = 1'b1;
                    if (r_cnt == CNT_W'(EOP_BITS - 1)) begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
                    end
                end
                ST_GAP: begin
                    // First gap strobe releases the line; the rest are idle bit times.
                    if (r_cnt == '0) begin
                        w_tx_data_nxt   = 1'b0;
                        w_tx_oe_nxt     = 1'b0;
                        w_call_eop_nxt  = 1'b0;
                        w_grant_pid_nxt = '0;
                        w_done_nxt      = 1'b1;
                    end
                    if (r_cnt == CNT_W'(GAP_BITS)) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // New requests are OR'd after clearing so a same-cycle request survives a grant.
        w_pend_nxt = (r_pend & ~w_clr) | {bus.reqStall, bus.reqNak, bus.reqAck};
    end

    assign bus.txData   = r_tx_data;
    assign bus.txOE     = r_tx_oe;
    assign bus.callEop  = r_call_eop;
    assign bus.busy     = r_busy;
    assign bus.grantPid = r_grant_pid;
    assign bus.done     = r_done;
    assign bus.dropped  = r_dropped;
endmodule

// File: tb/tb_usb_handshake_tx_sched.sv
module tb_usb_handshake_tx_sched;
    import usb_pkg::*;

    localparam int unsigned N_SYNC = 8;
    localparam int unsigned N_EOP  = 2;
    localparam int unsigned N_GAP  = 2;
    localparam int unsigned S_PID  = N_SYNC;              // first PID strobe
    localparam int unsigned S_EOP  = N_SYNC + 8;          // first EOP strobe
    localparam int unsigned S_DROP = N_SYNC + 8 + N_EOP;  // OE drops
    localparam int unsigned S_LAST = S_DROP + N_GAP;      // back to idle

    logic useClk = 1'b0;
    logic rst;
    usb_handshake_tx_sched_if bus ();

    usb_handshake_tx_sched dut (
        .useClk (useClk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 useClk = ~useClk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: packet position s since launch, pending set, PID.
    bit       m_active  = 1'b0;
    int       m_s       = 0;
    pid_t     m_pid     = '0;
    bit [2:0] m_pend    = '0;     // {stall, nak, ack}
    bit       m_done    = 1'b0;
    bit       m_dropped = 1'b0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Wire bit sequence of each handshake in transmit order (first bit = MSB).
    function automatic bit pid_wire_bit(input pid_t pid, input int k);
        bit [7:0] seq;
        case (pid)
            PID_ACK:   seq = 8'b01001011;
            PID_NAK:   seq = 8'b01011010;
            PID_STALL: seq = 8'b01111000;
            default:   seq = 8'b00000000;
        endcase
        return seq[7-k];
    endfunction

    task automatic model_step(input bit r, input bit s, input bit a, input bit n, input bit st);
        bit [2:0] clr;
        clr       = 3'b000;
        m_done    = 1'b0;
        m_dropped = 1'b0;
        if (r) begin
            m_active = 1'b0;
            m_s      = 0;
            m_pid    = '0;
            m_pend   = '0;
        end else begin
            if (s) begin
                if (!m_active) begin
                    if (m_pend[2]) begin
                        m_pid = PID_STALL; clr = 3'b111; m_dropped = (m_pend[1] || m_pend[0]);
                    end else if (m_pend[1]) begin
                        m_pid = PID_NAK;   clr = 3'b011; m_dropped = m_pend[0];
                    end else if (m_pend[0]) begin
                        m_pid = PID_ACK;   clr = 3'b001;
                    end
                    if (m_pend != 3'b000) begin
                        m_active = 1'b1;
                        m_s      = 0;
                    end
                end else if (m_s + 1 == S_LAST) begin
                    m_active = 1'b0;
                end else begin
                    m_s = m_s + 1;
                    if (m_s == S_DROP) m_done = 1'b1;
                end
            end
            m_pend = (m_pend & ~clr) | {st, n, a};
        end
    endtask

    task automatic check_all();
        bit   e_oe, e_eop, e_data;
        pid_t e_pid;
        e_oe   = m_active && (m_s < S_DROP);
        e_eop  = m_active && (m_s >= S_EOP) && (m_s < S_DROP);
        e_pid  = e_oe ? m_pid : 4'b0000;
        e_data = 1'b0;
        if (m_active && m_s < S_PID)      e_data = (m_s == N_SYNC - 1);
        else if (m_active && m_s < S_EOP) e_data = pid_wire_bit(m_pid, m_s - S_PID);
        chk("txData",   4'(bus.txData),  4'(e_data));
        chk("txOE",     4'(bus.txOE),    4'(e_oe));
        chk("callEop",  4'(bus.callEop), 4'(e_eop));
        chk("busy",     4'(bus.busy),    4'(m_active));
        chk("grantPid", bus.grantPid,    e_pid);
        chk("done",     4'(bus.done),    4'(m_done));
        chk("dropped",  4'(bus.dropped), 4'(m_dropped));
    endtask

    // One clock: drive inputs, advance model on the edge, check at negedge.
    task automatic cyc(input bit r, input bit s, input bit a, input bit n, input bit st);
        rst           = r;
        bus.checkData = s;
        bus.reqAck    = a;
        bus.reqNak    = n;
        bus.reqStall  = st;
        @(posedge useClk);
        model_step(r, s, a, n, st);
        @(negedge useClk);
        check_all();
    endtask

    task automatic run_idle(input int ncyc, input int period);
        for (int i = 0; i < ncyc; i++) cyc(1'b0, (i % period) == period - 1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt_done, cnt_drop, guard;
        bit seen;

        rst = 1'b1;
        bus.checkData = 1'b0; bus.reqAck = 1'b0; bus.reqNak = 1'b0; bus.reqStall = 1'b0;

        // Reset, with requests during reset that must be ignored.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_ignores_req", 4'(bus.busy), 4'd0);

        // Single ACK, strobe every 4th clock.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cnt_done = 0;
        for (int i = 0; i < 120; i++) begin
            cyc(1'b0, (i % 4) == 3, 1'b0, 1'b0, 1'b0);
            if (bus.done) cnt_done++;
        end
        chk("ack_done_count", 4'(cnt_done), 4'd1);

        // Priority: all three at once -> STALL, one dropped pulse, no second packet.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cnt_drop = 0; cnt_done = 0;
        for (int i = 0; i < 150; i++) begin
            cyc(1'b0, (i % 3) == 2, 1'b0, 1'b0, 1'b0);
            if (bus.dropped) cnt_drop++;
            if (bus.done) cnt_done++;
        end
        chk("prio_drop_count", 4'(cnt_drop), 4'd1);
        chk("prio_done_count", 4'(cnt_done), 4'd1);

        // NAK requested at s=5 of an ACK launches after the ACK completes.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (!(m_active && m_s == 5) && guard < 100) begin
            cyc(1'b0, (guard % 2) == 1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        chk("busy_reach_s5", 4'(guard < 100), 4'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            cyc(1'b0, (i % 2) == 1, 1'b0, 1'b0, 1'b0);
            if (bus.grantPid == PID_NAK) seen = 1'b1;
        end
        chk("nak_after_ack", 4'(seen), 4'd1);

        // Back-to-back strobes: txOE high exactly 18 clocks.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cnt_done = 0;
        for (int i = 0; i < 25; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (bus.txOE) cnt_done++;
        end
        chk("b2b_oe_clocks", 5'(cnt_done) == 5'd18 ? 4'd1 : 4'd0, 4'd1);

        // Reset at s=10: immediate abort, no done, then a normal launch.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (!(m_active && m_s == 10) && guard < 100) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        chk("rst_reach_s10", 4'(guard < 100), 4'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_idle(10, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_idle(40, 1);

        // No strobe for 100 clocks: request stays pending until the first strobe.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_idle(100, 1000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("late_launch_oe", 4'(bus.txOE), 4'd1);
        run_idle(30, 1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 23) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/usb_handshake_tx_sched.md
Name: usb_handshake_tx_sched

Overview:
Schedules the device-side handshake replies on the shared low/full-speed serial transmit path. Latches ACK, NAK and STALL requests from the receive/endpoint logic and arbitrates them by fixed priority. Sequences the granted packet bit by bit on the bit-rate strobe: SYNC, PID (LSB first, raw NRZ before NRZI), EOP request, then inter-packet gap. Sits between the protocol/endpoint logic and the NRZI encoder / line driver.

Parameters:
SYNC_BITS, 8, number of SYNC bits: SYNC_BITS-1 zeros followed by a single one
EOP_BITS, 2, bit times callEop is held high
GAP_BITS, 2, idle bit times after OE drops before a new launch is allowed

Ports:
useClk  in  1  system clock; single clock domain
rst  in  1  synchronous active-high reset
checkData  in  1  bit-rate strobe, one useClk cycle wide
reqAck  in  1  request ACK (pulse, any cycle)
reqNak  in  1  request NAK (pulse, any cycle)
reqStall  in  1  request STALL (pulse, any cycle)
txData  out  1  NRZ bit to the NRZI encoder
txOE  out  1  transmit output enable
callEop  out  1  request SE0 from the line driver
busy  out  1  high when state != IDLE
grantPid  out  4  PID nibble of the packet in flight (ACK 0010, NAK 1010, STALL 1110); 0000 when idle
done  out  1  one-useClk-cycle pulse when OE drops
dropped  out  1  one-useClk-cycle pulse when a pending request is discarded

Behaviour:
- Reset: all outputs 0, state IDLE, pending bits cleared, counters 0. Reset mid-packet aborts immediately with no EOP. A request arriving in the same cycle as rst is ignored.
- Request latch:
  - Each req pulse sets its pending bit on any useClk edge, independent of checkData.
  - A request arriving in the same cycle as a grant is kept pending.
- Arbitration:
  - Evaluated only in IDLE on a checkData cycle. Priority is STALL > NAK > ACK.
  - On grant, the winner's pending bit and all lower pending bits are cleared. If any lower bit was set, dropped pulses.
  - Requests accepted while busy stay pending and are arbitrated at the next launch.
- Strobe index s counts checkData cycles from launch, s=0. All sequencing advances only on checkData=1.
  - SYNC, s=0..SYNC_BITS-1: txOE<=1 at s=0, busy<=1, grantPid<=winner. txData = 0 for s<SYNC_BITS-1, and 1 at s=SYNC_BITS-1.
  - PID, next 8 strobes: txData = {~pid, pid} sent LSB first. ACK gives 0,1,0,0,1,0,1,1; NAK gives 0,1,0,1,1,0,1,0; STALL gives 0,1,1,1,1,0,0,0.
  - EOP, next EOP_BITS strobes: txData<=0, callEop<=1, txOE stays 1.
  - Next strobe, s=SYNC_BITS+8+EOP_BITS (18 at defaults): callEop<=0, txOE<=0, done pulses for exactly one useClk cycle, grantPid<=0.
  - GAP: GAP_BITS strobes, then IDLE; busy<=0 on entry to IDLE. Earliest next launch is the following strobe (s=21 at defaults).
- States: IDLE -> SYNC -> PID -> EOP -> GAP -> IDLE. There are no other transitions except reset to IDLE.
- Bit counter width is clog2(max(SYNC_BITS,8,EOP_BITS,GAP_BITS)+1) and wraps to 0 at each state change.
- Between strobes, outputs hold their values; done and dropped are the only non-strobe-aligned pulses.
- checkData held high on every cycle is legal and advances one bit per clock.

Decomposition:
- Shared package usb_pkg: PID constants (PID_ACK=4'b0010, PID_NAK=4'b1010, PID_STALL=4'b1110), state enum, and default SYNC/EOP/GAP constants.
- One sub-module, usb_pid_serializer: takes the 4-bit PID and bit index 0..7 and returns the LSB-first NRZ bit of {~pid, pid}. It is combinational and reused by the future data-packet transmitter.

Test Plan:
- Single ACK: pulse reqAck, checkData every 4th clock. txData over strobes 0..15 = 0000000 1 01001011; callEop high on s=16,17; txOE falls and done pulses at s=18.
- Priority: reqAck, reqNak and reqStall pulsed in the same cycle. grantPid=1110, PID bits = 01111000, dropped pulses once, and no second packet follows.
- Request while busy: reqNak at s=5 of an ACK. The ACK completes unchanged, then NAK launches at s=21 with grantPid=1010.
- Back-to-back strobe: checkData tied high. The full ACK finishes in 19 clocks with txOE high for exactly 18 clocks; busy falls 2 clocks later.
- Reset mid-packet: rst at s=10. Next cycle txOE=0, callEop=0, busy=0, grantPid=0, and no done pulse. A reqAck after reset launches normally.
- No strobe: reqAck with checkData=0 for 100 clocks. txOE stays 0 and the pending request is kept; launch happens on the first strobe.
